block_scheduler: RTL and testbench

Sequences the beat-block timeline for `game_logic_and_renderer`. It owns the song clock (`curr_time`) and walks a sorted beatmap memory. It maintains the window of live block indices the renderer and hit logic iterate over, and retires each block as hit or missed. It sits between the VGA frame timing, the beatmap BRAM and the game logic and renderer.

---
 rtl/block_scheduler.sv | 224 ++++++++++++++++++++++
 tb/tb_block_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_scheduler.sv
// block_scheduler
// Owns the song clock and walks a sorted beatmap memory. It keeps the window [head, tail)
// of live block indices and retires each block as hit or missed.
//
// Ports:
//   clk_in, rst_in        clock, synchronous active-low reset
//   start_in              one-cycle pulse that starts (or restarts) the song
//   frame_tick_in         one-cycle pulse per video frame
//   bm_addr_out           beatmap read address (data returns 2 cycles later)
//   bm_time_in            beatmap hit time
//   hit_valid_in          hit report from game logic
//   hit_idx_in            index of the block reported as hit
//   curr_time_out         song clock
//   active_head_out       first live index
//   active_tail_out       one past the last live index
//   busy_out              window update in progress; head/tail are unstable
//   hits_out, misses_out  retired block counters
//   done_out              all blocks retired
module block_scheduler #(
  parameter int unsigned NUM_BLOCKS      = 64,
  parameter int unsigned TIME_WIDTH      = 12,
  parameter int unsigned FRAMES_PER_TICK = 2,
  parameter int unsigned LOOKAHEAD       = 64,
  parameter int unsigned LATE_WINDOW     = 8,
  parameter int unsigned MAX_ACTIVE      = 8,
  localparam int unsigned IW = $clog2(NUM_BLOCKS + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  frame_tick_in,
  output logic [IW-1:0]         bm_addr_out,
  input  logic [TIME_WIDTH-1:0] bm_time_in,
  input  logic                  hit_valid_in,
  input  logic [IW-1:0]         hit_idx_in,
  output logic [TIME_WIDTH-1:0] curr_time_out,
  output logic [IW-1:0]         active_head_out,
  output logic [IW-1:0]         active_tail_out,
  output logic                  busy_out,
  output logic [IW-1:0]         hits_out,
  output logic [IW-1:0]         misses_out,
  output logic                  done_out
);

  localparam int unsigned FW = (FRAMES_PER_TICK > 1) ? $clog2(FRAMES_PER_TICK) : 1;
  localparam logic [FW-1:0]       FrameLast = FW'(FRAMES_PER_TICK - 1);
  localparam logic [TIME_WIDTH:0] LateW     = (TIME_WIDTH + 1)'(LATE_WINDOW);
  localparam logic [TIME_WIDTH:0] LookW     = (TIME_WIDTH + 1)'(LOOKAHEAD);
  localparam logic [IW:0]         MaxActW   = (IW + 1)'(MAX_ACTIVE);
  localparam logic [IW-1:0]       NumW      = IW'(NUM_BLOCKS);

  // Each read takes three states: address, BRAM latency, check.
  typedef enum logic [3:0] {
    StIdle,
    StRun,
    StRdHead,
    StWaitHead,
    StChkHead,
    StRdTail,
    StWaitTail,
    StChkTail,
    StDone
  } state_e;

  state_e                  state_q, state_d;
  logic [TIME_WIDTH-1:0]   time_q, time_d;
  logic [IW-1:0]           head_q, head_d;
  logic [IW-1:0]           tail_q, tail_d;
  logic [IW-1:0]           hits_q, hits_d;
  logic [IW-1:0]           misses_q, misses_d;
  logic [IW-1:0]           addr_q, addr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [NUM_BLOCKS-1:0]   mask_q, mask_d;
  logic [FW-1:0]           fcnt_q, fcnt_d;
  logic                    pend_q, pend_d;

  logic [TIME_WIDTH:0]     t_ext, now_ext;
  logic                    is_late, in_reach;
  logic [IW-1:0]           win_len;
  logic                    head_mask, hit_fwd, updating;

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    head_d   = head_q;
    tail_d   = tail_q;
    hits_d   = hits_q;
    misses_d = misses_q;
    mask_d   = mask_q;
    fcnt_d   = fcnt_q;
    pend_d   = pend_q;

    t_ext    = {1'b0, bm_time_in};
    now_ext  = {1'b0, time_q};
    is_late  = now_ext > (t_ext + LateW);
    in_reach = t_ext <= (now_ext + LookW);
    win_len  = tail_q - head_q;
    updating = (state_q != StIdle) && (state_q != StRun) && (state_q != StDone);

    head_mask = 1'b0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (IW'(i) == head_q) head_mask = mask_q[i];
    end
    // A hit landing in the same cycle as the retire of that block still counts.
    hit_fwd = hit_valid_in && (hit_idx_in == head_q);

    if (hit_valid_in && (state_q != StIdle) && (state_q != StDone) &&
        (hit_idx_in >= head_q) && (hit_idx_in < tail_q)) begin
      for (int i = 0; i < NUM_BLOCKS; i++) begin
        if (IW'(i) == hit_idx_in) mask_d[i] = 1'b1;
      end
    end

    // Ticks during an update are held for RUN; a second one is dropped.
    if (updating && frame_tick_in) pend_d = 1'b1;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_in) begin
          time_d   = '0;
          head_d   = '0;
          tail_d   = '0;
          hits_d   = '0;
          misses_d = '0;
          mask_d   = '0;
          fcnt_d   = '0;
          pend_d   = 1'b0;
          state_d  = StRdHead;
        end
      end
      StRun: begin
        if (frame_tick_in || pend_q) begin
          // Consume the pending tick first; a live tick in the same cycle stays pending.
          pend_d = frame_tick_in && pend_q;
          if (fcnt_q == FrameLast) begin
            fcnt_d  = '0;
            if (time_q != '1) time_d = time_q + 1'b1;
            state_d = StRdHead;
          end else begin
            fcnt_d = fcnt_q + 1'b1;
          end
        end
      end
      StRdHead:   state_d = StWaitHead;
      StWaitHead: state_d = StChkHead;
      StChkHead: begin
        if ((head_q < tail_q) && is_late) begin
          if (head_mask || hit_fwd) hits_d = hits_q + 1'b1;
          else                      misses_d = misses_q + 1'b1;
          head_d  = head_q + 1'b1;
          state_d = StRdHead;
        end else begin
          state_d = StRdTail;
        end
      end
      StRdTail: begin
        if ((tail_q == NumW) || ({1'b0, win_len} >= MaxActW)) begin
          state_d = (head_q == NumW) ? StDone : StRun;
        end else begin
          state_d = StWaitTail;
        end
      end
      StWaitTail: state_d = StChkTail;
      StChkTail: begin
        if (in_reach) begin
          tail_d  = tail_q + 1'b1;
          state_d = StRdTail;
        end else begin
          state_d = (head_q == NumW) ? StDone : StRun;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered address tracks the index the next read state will use.
    if (state_d == StRdHead)      addr_d = head_d;
    else if (state_d == StRdTail) addr_d = tail_d;
    else                          addr_d = addr_q;

    busy_d = (state_d != StIdle) && (state_d != StRun) && (state_d != StDone);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q  <= StIdle;
      time_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      hits_q   <= '0;
      misses_q <= '0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mask_q   <= '0;
      fcnt_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      hits_q   <= hits_d;
      misses_q <= misses_d;
      addr_q   <= addr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mask_q   <= mask_d;
      fcnt_q   <= fcnt_d;
      pend_q   <= pend_d;
    end
  end

  assign bm_addr_out     = addr_q;
  assign curr_time_out   = time_q;
  assign active_head_out = head_q;
  assign active_tail_out = tail_q;
  assign busy_out        = busy_q;
  assign hits_out        = hits_q;
  assign misses_out      = misses_q;
  assign done_out        = done_q;

endmodule

// File: tb/tb_block_scheduler.sv
// Directed bench for block_scheduler with a 4-entry beatmap {3,5,6,20} behind a
// 2-cycle-latency memory model.
module tb_block_scheduler;

  localparam int unsigned NB = 4;
  localparam int unsigned TW = 12;
  localparam int unsigned IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          tick;
  logic [IW-1:0] bm_addr;
  logic [TW-1:0] bm_time;
  logic          hit_valid;
  logic [IW-1:0] hit_idx;
  logic [TW-1:0] curr_time;
  logic [IW-1:0] head;
  logic [IW-1:0] tail;
  logic          busy;
  logic [IW-1:0] hits;
  logic [IW-1:0] misses;
  logic          done;

  logic [TW-1:0] bm_mem [8];
  logic [IW-1:0] addr_d1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  block_scheduler #(
    .NUM_BLOCKS     (NB),
    .TIME_WIDTH     (TW),
    .FRAMES_PER_TICK(2),
    .LOOKAHEAD      (4),
    .LATE_WINDOW    (2),
    .MAX_ACTIVE     (2)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .start_in       (start),
    .frame_tick_in  (tick),
    .bm_addr_out    (bm_addr),
    .bm_time_in     (bm_time),
    .hit_valid_in   (hit_valid),
    .hit_idx_in     (hit_idx),
    .curr_time_out  (curr_time),
    .active_head_out(head),
    .active_tail_out(tail),
    .busy_out       (busy),
    .hits_out       (hits),
    .misses_out     (misses),
    .done_out       (done)
  );

  // Two-cycle read latency memory.
  always @(posedge clk) begin
    addr_d1 <= bm_addr;
    bm_time <= bm_mem[addr_d1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100 && busy; i++) cyc(1);
    check({tag, "_settle"}, 32'(busy), 0);
  endtask

  // Two frame ticks per song-clock step, then let the update finish.
  task automatic step(input int n);
    repeat (n) begin
      pulse_tick();
      pulse_tick();
      wait_idle("step");
    end
  endtask

  task automatic hit(input logic [IW-1:0] idx);
    hit_valid = 1'b1;
    hit_idx   = idx;
    cyc(1);
    hit_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_time"},   32'(curr_time), 0);
    check({tag, "_head"},   32'(head),      0);
    check({tag, "_tail"},   32'(tail),      0);
    check({tag, "_busy"},   32'(busy),      0);
    check({tag, "_hits"},   32'(hits),      0);
    check({tag, "_misses"}, 32'(misses),    0);
    check({tag, "_done"},   32'(done),      0);
    check({tag, "_addr"},   32'(bm_addr),   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bm_mem[0] = 12'd3;
    bm_mem[1] = 12'd5;
    bm_mem[2] = 12'd6;
    bm_mem[3] = 12'd20;
    for (int i = 4; i < 8; i++) bm_mem[i] = '1;
    rst_n = 1'b0; start = 1'b0; tick = 1'b0; hit_valid = 1'b0; hit_idx = '0;
    cyc(3);
    chk_zero("reset");

    // Ticks before start do nothing.
    rst_n = 1'b1;
    repeat (4) pulse_tick();
    cyc(2);
    check("idle_time", 32'(curr_time), 0);
    check("idle_busy", 32'(busy), 0);

    // Start, then reset while in the second tail read (tail already 1).
    start = 1'b1; cyc(1); start = 1'b0;
    cyc(6);
    check("mid_busy", 32'(busy), 1);
    check("mid_tail", 32'(tail), 1);
    check("mid_addr", 32'(bm_addr), 1);
    rst_n = 1'b0; cyc(1);
    chk_zero("rst_mid");
    rst_n = 1'b1;
    cyc(10);
    check("abort_busy", 32'(busy), 0);
    check("abort_tail", 32'(tail), 0);

    // Start and fill.
    start = 1'b1; cyc(1); start = 1'b0;
    wait_idle("start");
    check("t0_time", 32'(curr_time), 0);
    check("t0_head", 32'(head), 0);
    check("t0_tail", 32'(tail), 1);
    step(1);
    check("t1_time", 32'(curr_time), 1);
    check("t1_tail", 32'(tail), 2);
    step(1);
    check("t2_time", 32'(curr_time), 2);
    check("t2_tail_full", 32'(tail), 2);

    // Hit and refill.
    step(1);
    hit(3'd0);
    check("t3_hits", 32'(hits), 0);
    step(2);
    check("t5_head", 32'(head), 0);
    check("t5_hits", 32'(hits), 0);
    step(1);
    check("t6_hits", 32'(hits), 1);
    check("t6_head", 32'(head), 1);
    check("t6_tail", 32'(tail), 3);
    check("t6_misses", 32'(misses), 0);

    // Duplicate / out-of-window hits, then misses.
    hit(3'd0);
    hit(3'd0);
    hit(3'd3);
    check("dup_hits", 32'(hits), 1);
    step(1);
    check("t7_misses", 32'(misses), 0);
    step(1);
    check("t8_misses", 32'(misses), 1);
    check("t8_head", 32'(head), 2);
    step(1);
    check("t9_misses", 32'(misses), 2);
    check("t9_head", 32'(head), 3);
    check("t9_hits", 32'(hits), 1);

    // Two ticks during an update: one is kept, the second dropped.
    pulse_tick();
    pulse_tick();
    check("pend_busy", 32'(busy), 1);
    pulse_tick();
    pulse_tick();
    wait_idle("pend");
    check("t10_time", 32'(curr_time), 10);
    cyc(5);
    check("pend_once", 32'(curr_time), 10);
    pulse_tick();
    wait_idle("pend2");
    check("t11_time", 32'(curr_time), 11);

    // Completion.
    step(5);
    check("t16_time", 32'(curr_time), 16);
    check("t16_tail", 32'(tail), 4);
    check("t16_head", 32'(head), 3);
    step(6);
    check("t22_head", 32'(head), 3);
    check("t22_done", 32'(done), 0);
    step(1);
    check("t23_time", 32'(curr_time), 23);
    check("t23_head", 32'(head), 4);
    check("t23_done", 32'(done), 1);
    check("t23_misses", 32'(misses), 3);
    check("t23_hits", 32'(hits), 1);
    repeat (4) pulse_tick();
    cyc(2);
    check("done_hold", 32'(curr_time), 23);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
